// File: rtl/aes_key_schedule_seq.sv
// Sequential AES key expansion: one schedule word per cycle into a register array,
// with combinational read-out of any completed round key.

module sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte 0 of the table sits in the top bits, so index from the MSB end.
    always_comb begin
        out_byte = SBOX_TABLE[{~in_byte, 3'b000} +: 8];
    end
endmodule

module aes_key_schedule_seq #(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         err,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key,
    output logic         rd_valid
);
    localparam int MAX_NK = MAX_KEY_BITS / 32;
    localparam int WORDS  = 4 * (MAX_NK + 7);

    typedef enum logic {IDLE = 1'b0, EXPAND = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [31:0] w_q [WORDS];
    logic [31:0] w_d [WORDS];
    logic [5:0]  i_q, i_d;
    logic [2:0]  kcnt_q, kcnt_d;
    logic [3:0]  nk_q, nk_d;
    logic [3:0]  nr_q, nr_d;
    logic [7:0]  rcon_q, rcon_d;
    logic        complete_q, complete_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic        len_ok_s;
    logic [3:0]  len_nk_s;
    logic [3:0]  len_nr_s;
    logic [31:0] prev_s;
    logic [31:0] sub_in_s;
    logic [31:0] sub_out_s;
    logic [31:0] temp_s;
    logic [5:0]  rd_idx_s;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Decode key length into Nk/Nr and check it against the build's maximum.
    always_comb begin
        case (key_len)
            2'b00:   begin len_ok_s = 1'b1;                  len_nk_s = 4'd4; len_nr_s = 4'd10; end
            2'b01:   begin len_ok_s = (MAX_KEY_BITS >= 192); len_nk_s = 4'd6; len_nr_s = 4'd12; end
            2'b10:   begin len_ok_s = (MAX_KEY_BITS >= 256); len_nk_s = 4'd8; len_nr_s = 4'd14; end
            default: begin len_ok_s = 1'b0;                  len_nk_s = 4'd8; len_nr_s = 4'd14; end
        endcase
    end

    // kcnt_q tracks i mod Nk so no divider is needed.
    always_comb begin
        prev_s   = w_q[i_q - 6'd1];
        sub_in_s = (kcnt_q == 3'd0) ? {prev_s[23:0], prev_s[31:24]} : prev_s;
        if (kcnt_q == 3'd0) begin
            temp_s = sub_out_s ^ {rcon_q, 24'h000000};
        end else if ((nk_q == 4'd8) && (kcnt_q == 3'd4)) begin
            temp_s = sub_out_s;
        end else begin
            temp_s = prev_s;
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_sub
        sbox u_sbox (.in_byte(sub_in_s[8*b +: 8]), .out_byte(sub_out_s[8*b +: 8]));
    end

    // Next-state: key load on accept, one schedule word per EXPAND cycle.
    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        i_d        = i_q;
        kcnt_d     = kcnt_q;
        nk_d       = nk_q;
        nr_d       = nr_q;
        rcon_d     = rcon_q;
        complete_d = complete_q;
        err_d      = err_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                if (start && len_ok_s) begin
                    for (int k = 0; k < MAX_NK; k++) begin
                        if (k < int'(len_nk_s)) begin
                            w_d[k] = key_in[255 - 32*k -: 32];
                        end else begin
                            w_d[k] = w_q[k];
                        end
                    end
                    state_d    = EXPAND;
                    i_d        = {2'b00, len_nk_s};
                    kcnt_d     = 3'd0;
                    nk_d       = len_nk_s;
                    nr_d       = len_nr_s;
                    rcon_d     = 8'h01;
                    complete_d = 1'b0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                end else if (start) begin
                    err_d      = 1'b1;
                    complete_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            EXPAND: begin
                w_d[i_q] = w_q[i_q - {2'b00, nk_q}] ^ temp_s;
                i_d      = i_q + 6'd1;
                kcnt_d   = ({1'b0, kcnt_q} == (nk_q - 4'd1)) ? 3'd0 : kcnt_q + 3'd1;
                if (kcnt_q == 3'd0) begin
                    rcon_d = xtime(rcon_q);
                end else begin
                    rcon_d = rcon_q;
                end
                if (i_q == {nr_q, 2'b11}) begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    complete_d = 1'b1;
                end else begin
                    state_d = EXPAND;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            i_q        <= 6'd0;
            kcnt_q     <= 3'd0;
            nk_q       <= 4'd4;
            nr_q       <= 4'd10;
            rcon_q     <= 8'h01;
            complete_q <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            kcnt_q     <= kcnt_d;
            nk_q       <= nk_d;
            nr_q       <= nr_d;
            rcon_q     <= rcon_d;
            complete_q <= complete_d;
            err_q      <= err_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // Word array is unreset; stale contents are hidden behind rd_valid.
    always_ff @(posedge clk) begin
        w_q <= w_d;
    end

    // Round-key read-out, zeroed unless the schedule is complete and in range.
    always_comb begin
        rd_idx_s = {rd_round, 2'b00};
        rd_valid = complete_q && (rd_round <= nr_q);
        if (rd_valid) begin
            rd_key = {w_q[rd_idx_s], w_q[rd_idx_s | 6'd1], w_q[rd_idx_s | 6'd2], w_q[rd_idx_s | 6'd3]};
        end else begin
            rd_key = 128'h0;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed bench for aes_key_schedule_seq using FIPS-197 key expansion vectors,
// with a second instance built for 128-bit keys only.

module tb_aes_key_schedule_seq;
    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic [3:0]   rd_round;
    logic         busy, done, err, rd_valid;
    logic [127:0] rd_key;
    logic         start_m;
    logic [1:0]   key_len_m;
    logic         busy_m, done_m, err_m, rd_valid_m;
    logic [127:0] rd_key_m;

    int tests_run = 0;
    int failed    = 0;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_cafef00d_01234567_89abcdef};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffffffff_00000000};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    aes_key_schedule_seq #(.MAX_KEY_BITS(256)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key_in(key_in),
        .busy(busy), .done(done), .err(err), .rd_round(rd_round), .rd_key(rd_key), .rd_valid(rd_valid)
    );

    aes_key_schedule_seq #(.MAX_KEY_BITS(128)) dut_m (
        .clk(clk), .rst_n(rst_n), .start(start_m), .key_len(key_len_m), .key_in(key_in),
        .busy(busy_m), .done(done_m), .err(err_m), .rd_round(rd_round), .rd_key(rd_key_m), .rd_valid(rd_valid_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns edges from accept to done, and rd_valid/busy just after accept.
    task automatic run_expand(input logic [1:0] len, input logic [255:0] key,
                              output int cycles, output logic v_acc, output logic b_acc);
        start   = 1'b1;
        key_len = len;
        key_in  = key;
        @(negedge clk);
        start  = 1'b0;
        v_acc  = rd_valid;
        b_acc  = busy;
        cycles = 0;
        while (done !== 1'b1 && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; start_m = 1'b0; key_len = 2'b00; key_len_m = 2'b00;
        key_in = 256'h0; rd_round = 4'd0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, done, err, rd_valid} !== 4'b0000) begin
            failed++; $display("FAIL reset_flags got %b exp 0000", {busy, done, err, rd_valid});
        end
        tests_run++;
        if (rd_key !== 128'h0) begin
            failed++; $display("FAIL reset_rd_key got %h exp 0", rd_key);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aes128;
        int c; logic v, b;
        run_expand(2'b00, K128, c, v, b);
        tests_run++;
        if (b !== 1'b1) begin failed++; $display("FAIL a128_busy got %b exp 1", b); end
        tests_run++;
        if (c !== 40) begin failed++; $display("FAIL a128_latency got %0d exp 40", c); end
        tests_run++;
        if (busy !== 1'b0) begin failed++; $display("FAIL a128_busy_done got %b exp 0", busy); end
        rd_round = 4'd0; #1;
        tests_run++;
        if (rd_key !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
            failed++; $display("FAIL a128_round0 got %h exp 2b7e151628aed2a6abf7158809cf4f3c", rd_key);
        end
        rd_round = 4'd1; #1;
        tests_run++;
        if (rd_key !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            failed++; $display("FAIL a128_round1 got %h exp a0fafe1788542cb123a339392a6c7605", rd_key);
        end
        rd_round = 4'd10; #1;
        tests_run++;
        if (rd_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || rd_valid !== 1'b1) begin
            failed++; $display("FAIL a128_round10 got %h v=%b exp d014f9a8c9ee2589e13f0cc8b6630ca6 v=1", rd_key, rd_valid);
        end
        rd_round = 4'd11; #1;
        tests_run++;
        if (rd_valid !== 1'b0 || rd_key !== 128'h0) begin
            failed++; $display("FAIL a128_round11 got v=%b %h exp v=0 0", rd_valid, rd_key);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin failed++; $display("FAIL a128_done_pulse got %b exp 0", done); end
    endtask

    task automatic test_aes192;
        int c; logic v, b;
        run_expand(2'b01, K192, c, v, b);
        tests_run++;
        if (c !== 46) begin failed++; $display("FAIL a192_latency got %0d exp 46", c); end
        rd_round = 4'd1; #1;
        tests_run++;
        if (rd_key !== 128'h62f8ead2522c6b7bfe0c91f72402f5a5) begin
            failed++; $display("FAIL a192_round1 got %h exp 62f8ead2522c6b7bfe0c91f72402f5a5", rd_key);
        end
        rd_round = 4'd12; #1;
        tests_run++;
        if (rd_key !== 128'he98ba06f448c773c8ecc720401002202) begin
            failed++; $display("FAIL a192_round12 got %h exp e98ba06f448c773c8ecc720401002202", rd_key);
        end
        rd_round = 4'd13; #1;
        tests_run++;
        if (rd_valid !== 1'b0 || rd_key !== 128'h0) begin
            failed++; $display("FAIL a192_round13 got v=%b %h exp v=0 0", rd_valid, rd_key);
        end
        @(negedge clk);
    endtask

    task automatic test_aes256;
        int c; logic v, b;
        run_expand(2'b10, K256, c, v, b);
        tests_run++;
        if (c !== 52) begin failed++; $display("FAIL a256_latency got %0d exp 52", c); end
        rd_round = 4'd2; #1;
        tests_run++;
        if (rd_key !== 128'h9ba354118e6925afa51a8b5f2067fcde) begin
            failed++; $display("FAIL a256_round2 got %h exp 9ba354118e6925afa51a8b5f2067fcde", rd_key);
        end
        rd_round = 4'd14; #1;
        tests_run++;
        if (rd_key !== 128'hfe4890d1e6188d0b046df344706c631e) begin
            failed++; $display("FAIL a256_round14 got %h exp fe4890d1e6188d0b046df344706c631e", rd_key);
        end
        @(negedge clk);
    endtask

    task automatic test_illegal;
        int c; logic v, b; bit saw_done;
        start = 1'b1; key_len = 2'b11; key_in = K256;
        @(negedge clk);
        start = 1'b0;
        rd_round = 4'd0; #1;
        tests_run++;
        if ({err, busy, rd_valid} !== 3'b100) begin
            failed++; $display("FAIL illegal_flags got err/busy/valid=%b exp 100", {err, busy, rd_valid});
        end
        saw_done = 1'b0;
        repeat (45) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done !== 1'b0) begin failed++; $display("FAIL illegal_no_done got %b exp 0", saw_done); end
        run_expand(2'b00, K128, c, v, b);
        tests_run++;
        if (err !== 1'b0 || c !== 40) begin
            failed++; $display("FAIL illegal_recover got err=%b lat=%0d exp err=0 lat=40", err, c);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int c; logic v, b;
        start = 1'b1; key_len = 2'b10; key_in = K256;
        @(negedge clk);
        key_len = 2'b00; key_in = K128;
        c = 0;
        while (done !== 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        tests_run++;
        if (c !== 52) begin failed++; $display("FAIL b2b_held_start_latency got %0d exp 52", c); end
        rd_round = 4'd14; #1;
        tests_run++;
        if (rd_key !== 128'hfe4890d1e6188d0b046df344706c631e) begin
            failed++; $display("FAIL b2b_round14 got %h exp fe4890d1e6188d0b046df344706c631e", rd_key);
        end
        @(negedge clk);
        rd_round = 4'd0;
        run_expand(2'b00, K128, c, v, b);
        tests_run++;
        if (v !== 1'b0 || b !== 1'b1) begin
            failed++; $display("FAIL b2b_accept got valid=%b busy=%b exp valid=0 busy=1", v, b);
        end
        run_expand(2'b01, K192, c, v, b);
        tests_run++;
        if (v !== 1'b0 || b !== 1'b1 || c !== 46) begin
            failed++; $display("FAIL b2b_after_done got valid=%b busy=%b lat=%0d exp 0 1 46", v, b, c);
        end
        rd_round = 4'd12; #1;
        tests_run++;
        if (rd_key !== 128'he98ba06f448c773c8ecc720401002202) begin
            failed++; $display("FAIL b2b_round12 got %h exp e98ba06f448c773c8ecc720401002202", rd_key);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int c; logic v, b; bit saw_done;
        start = 1'b1; key_len = 2'b10; key_in = K256;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        rd_round = 4'd0; #1;
        tests_run++;
        if ({busy, done, rd_valid} !== 3'b000) begin
            failed++; $display("FAIL midreset_flags got busy/done/valid=%b exp 000", {busy, done, rd_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done === 1'b1 || rd_valid === 1'b1) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done !== 1'b0) begin failed++; $display("FAIL midreset_quiet got %b exp 0", saw_done); end
        run_expand(2'b10, K256, c, v, b);
        rd_round = 4'd14; #1;
        tests_run++;
        if (c !== 52 || rd_key !== 128'hfe4890d1e6188d0b046df344706c631e) begin
            failed++; $display("FAIL midreset_restart got lat=%0d %h exp 52 fe4890d1e6188d0b046df344706c631e", c, rd_key);
        end
        @(negedge clk);
    endtask

    task automatic test_max128;
        int c;
        start_m = 1'b1; key_len_m = 2'b01; key_in = K192;
        @(negedge clk);
        start_m = 1'b0;
        tests_run++;
        if (err_m !== 1'b1 || busy_m !== 1'b0) begin
            failed++; $display("FAIL max128_reject got err=%b busy=%b exp 1 0", err_m, busy_m);
        end
        start_m = 1'b1; key_len_m = 2'b00; key_in = K128;
        @(negedge clk);
        start_m = 1'b0;
        c = 0;
        while (done_m !== 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        rd_round = 4'd10; #1;
        tests_run++;
        if (c !== 40 || err_m !== 1'b0 || rd_key_m !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            failed++; $display("FAIL max128_a128 got lat=%0d err=%b %h exp 40 0 d014f9a8c9ee2589e13f0cc8b6630ca6", c, err_m, rd_key_m);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_max128();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule

// File: doc/aes_key_schedule_seq.md
AES_KEY_SCHEDULE_SEQ -- requirements
Module: aes_key_schedule_seq

Interface
REQ-001 The block SHALL have one parameter: MAX_KEY_BITS, default 256, legal values 128/192/256, the largest key length supported.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset SHALL be asynchronous and active-low.
REQ-004 start  input  1  request expansion; SHALL be sampled only in IDLE.
REQ-005 key_len  input  2  key length: 00=128, 01=192, 10=256, 11=illegal.
REQ-006 key_in  input  256  cipher key; key byte 0 is at [255:248]; 128/192-bit keys SHALL be left-justified, low bits ignored.
REQ-007 busy  output  1  expansion in progress.
REQ-008 done  output  1  one-cycle pulse when the schedule is complete.
REQ-009 err  output  1  sticky flag: last start carried an unsupported key_len.
REQ-010 rd_round  input  4  round-key index to read.
REQ-011 rd_key  output  128  round key rd_round, word 4r at [127:96].
REQ-012 rd_valid  output  1  rd_key holds a valid key.

Function
REQ-013 Nk/Nr SHALL be 4/10, 6/12, 8/14 for 128/192/256; total words T=4*(Nr+1)=44/52/60.
REQ-014 Storage SHALL be a register array of 4*(MAX_KEY_BITS/32+7) 32-bit words (44/52/60).
REQ-015 FSM states SHALL be IDLE and EXPAND only.
REQ-016 IDLE with start=1 and a supported key_len: same edge writes w[0..Nk-1] from key_in, clears the complete flag and err, sets busy, presets rcon=8'h01, index i=Nk, goes to EXPAND.
REQ-017 A key_len of 11, or one exceeding MAX_KEY_BITS: set err, clear the complete flag, stay IDLE, busy stays 0, no done.
REQ-018 EXPAND SHALL write exactly one word per cycle: w[i]=w[i-Nk]^temp, temp=w[i-1] by default.
REQ-019 When i mod Nk==0: temp=SubWord(RotWord(w[i-1]))^{rcon,24'h0}; then rcon updates to xtime(rcon) (shift left 1, XOR 8'h1b on carry-out).
REQ-020 When Nk==8 and i mod 8==4: temp=SubWord(w[i-1]), no rotate, no rcon.
REQ-021 SubWord SHALL use four instances of the existing sbox module.
REQ-022 On the edge that writes w[T-1]: return to IDLE, busy<=0, done<=1 for exactly one cycle, complete flag set.
REQ-023 Latency from the start-accept edge to done asserted SHALL be T-Nk cycles: 40/46/52.
REQ-024 start while busy SHALL be ignored; no restart, no queuing.
REQ-025 rd_valid SHALL be complete && rd_round<=Nr of the last accepted key; it is combinational.
REQ-026 rd_key SHALL be combinational {w[4r],w[4r+1],w[4r+2],w[4r+3]} when rd_valid, else 128'h0.
REQ-027 A new accepted start SHALL drop rd_valid on its accept edge; the old schedule is not readable during expansion.
REQ-028 start coincident with done is impossible (busy=1); start on the cycle after done SHALL be accepted.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, busy=0, done=0, err=0, complete=0, rcon=8'h01, i=0.
REQ-030 Reset mid-expansion SHALL abort with no done pulse; rd_valid stays 0 until a later full expansion.
REQ-031 Word-array contents need no reset value; they are masked by rd_valid.

Verification
REQ-032 AES-128 key 2b7e151628aed2a6abf7158809cf4f3c -> done 40 cycles after accept; round 0 = key; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-033 AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done after 46 cycles; round 12 = e98ba06f448c773c8ecc720401002202; rd_round=13 -> rd_valid=0, rd_key=0.
REQ-034 AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 52 cycles; round 14 = fe4890d1e6188d0b046df344706c631e.
REQ-035 key_len=11 start -> err=1, busy=0, no done; then a valid start -> err=0, expansion proceeds.
REQ-036 Reset pulse at cycle 20 of AES-256 -> busy=0, done never pulses, rd_valid=0; a restart then yields the REQ-034 result; start pulses held high during busy are ignored.
REQ-037 MAX_KEY_BITS=128 build: key_len=01 -> err=1; the REQ-032 vector still passes.
